pipeline_perf_monitor: RTL and testbench
========================================

Name: pipeline_perf_monitor

Overview:
- Synthesizable performance monitor for the pipelined CPU.
- Counts elapsed run cycles plus NUM_EVT pipeline events (stall, flush, branch-taken, load-use, and so on) while the CPU is started.
- Halts counting at a programmable cycle limit.
- Exposes a snapshot bank through an indexed, registered read port, so the bench and on-chip debug read stable values instead of probing internals.

Parameters:
- NUM_EVT, 2: number of event inputs (1..15).
- CNT_W, 32: width of every counter, cycle counter included (4..32).
- CYCLE_LIMIT, 70: cycle count at which counting halts; 0 disables the limit.
- SATURATE, 1: 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  CPU start; counting is enabled only while high.
- evt_i  in  NUM_EVT  per-cycle event strobes; bit k increments event counter k.
- clear_i  in  1  zero all live counters and overflow flags, return to IDLE.
- snap_i  in  1  copy live counters into the shadow bank.
- rd_sel_i  in  4  shadow index: 0 = cycle counter, 1..NUM_EVT = event k-1.
- rd_data_o  out  CNT_W  registered shadow value.
- snap_valid_o  out  1  one-cycle pulse when the shadow bank has been updated.
- halt_o  out  1  high while in HALTED.
- ovf_o  out  NUM_EVT+1  sticky overflow flags, same indexing as rd_sel_i.

Behaviour:
- Reset (rst_i=1 at a clk_i edge) has priority over all other inputs. Result: live counters, shadow bank, rd_data_o, ovf_o, snap_valid_o and halt_o all 0; state IDLE. Reset mid-run aborts everything with no residual state.
- States and transitions:
  - IDLE: start_i=1 -> RUN.
  - RUN: start_i=0 -> IDLE, counters hold.
  - RUN: cycle counter reaches CYCLE_LIMIT (CYCLE_LIMIT != 0) -> HALTED.
  - HALTED: exits only on clear_i or rst_i.
- Counting:
  - In RUN, the cycle counter increments by 1 every cycle.
  - Event counter k increments in the same cycle that evt_i[k]=1.
  - No counting in IDLE or HALTED.
  - Transition cycle: the edge that moves IDLE->RUN does not count. The edge that brings the cycle counter to CYCLE_LIMIT counts, including any events present on that edge. halt_o=1 from that edge onward.
- Overflow:
  - An increment at all-ones sets ovf_o[idx] (sticky).
  - SATURATE=1: value holds at all-ones.
  - SATURATE=0: value wraps to 0.
- clear_i: next edge zeroes live counters and ovf_o, state -> IDLE. Clear beats a simultaneous increment, so the result is 0.
- snap_i: next edge loads the shadow bank with the live values before that edge's increment or clear. snap_valid_o=1 for exactly the following cycle. With snap_i and clear_i together, the shadow gets the pre-clear values and live counters go to 0.
- Read port: rd_data_o at edge t+1 = shadow[rd_sel_i sampled at edge t], a 1-cycle latency. rd_sel_i > NUM_EVT returns 0. Reads never disturb counting.
- All arithmetic is unsigned CNT_W-bit; no carry beyond CNT_W.

Decomposition:
- Shared package perf_pkg holds:
  - state enum {IDLE, RUN, HALTED}, 2 bits;
  - index constant CYC_IDX=0;
  - function evt_idx(k)=k+1.
- One sub-module, perf_counter_cell, parameterised by CNT_W and SATURATE. Inputs: inc, clr, rst; outputs: value, sticky ovf. It is instantiated NUM_EVT+1 times via generate.
- The FSM, snapshot bank and read mux stay in the top module.

Test Plan:
1. Defaults: after reset, start_i=1 for 10 cycles, evt_i[0] high on alternate cycles, evt_i[1] high on 3 cycles; then start_i=0, pulse snap_i -> snap_valid_o pulses; reads give sel0=10, sel1=5, sel2=3; ovf_o=0.
2. Cycle limit: start_i held high with evt_i[0] constantly high -> halt_o rises on the edge where the cycle counter reaches 70; sel0=70 and sel1=70 after snapshot; 10 more cycles leave both at 70; clear_i -> halt_o=0 and counters read 0.
3. Overflow: CNT_W=4, evt_i[1] high for 20 run cycles. SATURATE=1 -> sel2=15, ovf_o[2]=1. SATURATE=0 -> sel2=4, ovf_o[2]=1. Both cases: ovf_o[0]=1 (the cycle counter also overflows).
4. Simultaneous snap_i+clear_i with live sel1=7 -> shadow sel1=7, live counter 0; a second snapshot reads 0.
5. clear_i and evt_i[0] in the same cycle, live value 3 -> live value 0, not 1.
6. rst_i asserted mid-run at cycle 25 -> next edge: all outputs 0, state IDLE; restart counts from 0.

Source files
------------

// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared types and index helpers for the pipeline performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned CYC_IDX = 0;

    // Event k lives one slot above the cycle counter in every indexed view.
    function automatic int unsigned evt_idx(input int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One live counter with clear, sticky overflow and saturate-or-wrap policy.
module perf_counter_cell #(
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] value_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] r_value;
    logic             r_ovf;

    // Clear outranks a same-cycle increment; overflow flag is sticky until clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else if (inc_i) begin
            if (r_value == MAX_VAL) begin
                r_ovf   <= 1'b1;
                r_value <= SATURATE ? MAX_VAL : '0;
            end else begin
                r_value <= r_value + CNT_W'(1);
            end
        end
    end

    assign value_o = r_value;
    assign ovf_o   = r_ovf;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Run-cycle and pipeline-event monitor with cycle limit, snapshot bank and read port.
module pipeline_perf_monitor
    import perf_pkg::*;
#(
    parameter int unsigned NUM_EVT     = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned CYCLE_LIMIT = 70,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               clear_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               snap_valid_o,
    output logic               halt_o,
    output logic [NUM_EVT:0]   ovf_o
);

    localparam int unsigned NUM_CNT   = NUM_EVT + 1;
    localparam logic [32:0] LIMIT_EXT = 33'(CYCLE_LIMIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_halt;
    logic               w_count_en;
    logic               w_at_limit;
    logic [NUM_CNT-1:0] w_inc;
    logic [NUM_CNT-1:0] w_ovf;
    logic [CNT_W-1:0]   w_value  [NUM_CNT];
    logic [CNT_W-1:0]   r_shadow [NUM_CNT];
    logic [CNT_W-1:0]   w_rd_mux;
    logic [CNT_W-1:0]   r_rd_data;
    logic               r_snap_valid;

    // Counting happens only on edges spent in RUN with start held.
    always_comb begin
        w_count_en = (r_state == RUN) && start_i;
        w_at_limit = (CYCLE_LIMIT != 0) &&
                     ((33'(w_value[CYC_IDX]) + 33'd1) == LIMIT_EXT);
        w_inc      = '0;
        w_inc[CYC_IDX] = w_count_en;
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            w_inc[evt_idx(k)] = w_count_en && evt_i[k];
        end
    end

    // State register; halt flag tracks the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_halt  <= (w_state_nxt == HALTED);
        end
    end

    // Next-state logic; clear returns to IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start_i) w_state_nxt = RUN;
            RUN: begin
                if (w_count_en && w_at_limit) w_state_nxt = HALTED;
                else if (!start_i)            w_state_nxt = IDLE;
            end
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = IDLE;
        endcase
        if (clear_i) w_state_nxt = IDLE;
    end

    // Slot 0 is the cycle counter, slots 1..NUM_EVT are the event counters.
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clear_i),
            .inc_i   (w_inc[g]),
            .value_o (w_value[g]),
            .ovf_o   (w_ovf[g])
        );
    end

    // Out-of-range selects read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (rd_sel_i == SEL_W'(i)) w_rd_mux = r_shadow[i];
        end
    end

    // Shadow bank captures pre-edge live values; read port adds one cycle of latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) r_shadow[i] <= '0;
            r_rd_data    <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            if (snap_i) begin
                for (int unsigned i = 0; i < NUM_CNT; i++) r_shadow[i] <= w_value[i];
            end
            r_rd_data    <= w_rd_mux;
            r_snap_valid <= snap_i;
        end
    end

    assign rd_data_o    = r_rd_data;
    assign snap_valid_o = r_snap_valid;
    assign halt_o       = r_halt;
    assign ovf_o        = w_ovf;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench: default monitor plus two 4-bit instances (saturate / wrap) on shared stimulus.
module tb_pipeline_perf_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  evt = 2'b00;
    logic        clear = 1'b0;
    logic        snap = 1'b0;
    logic [3:0]  rd_sel = 4'd0;

    logic [31:0] rd_main;
    logic [3:0]  rd_sat, rd_wrap;
    logic        sv_main, sv_sat, sv_wrap;
    logic        halt_main, halt_sat, halt_wrap;
    logic [2:0]  ovf_main, ovf_sat, ovf_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int unsigned dut;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    pipeline_perf_monitor #(.NUM_EVT(2), .CNT_W(32), .CYCLE_LIMIT(70), .SATURATE(1'b1)) u_main (
        .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_main), .snap_valid_o(sv_main), .halt_o(halt_main), .ovf_o(ovf_main));

    pipeline_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .CYCLE_LIMIT(0), .SATURATE(1'b1)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_sat), .snap_valid_o(sv_sat), .halt_o(halt_sat), .ovf_o(ovf_sat));

    pipeline_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .CYCLE_LIMIT(0), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_wrap), .snap_valid_o(sv_wrap), .halt_o(halt_wrap), .ovf_o(ovf_wrap));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Push expected shadow values for the masked instances, then pop after the read latency.
    task automatic rd(input string tag, input logic [3:0] sel, input logic [2:0] mask,
                      input logic [31:0] e_main, input logic [31:0] e_sat, input logic [31:0] e_wrap);
        sb_t         s;
        logic [31:0] obs;
        rd_sel = sel;
        if (mask[0]) sbq.push_back('{{tag, "_main"}, 0, e_main});
        if (mask[1]) sbq.push_back('{{tag, "_sat"},  1, e_sat});
        if (mask[2]) sbq.push_back('{{tag, "_wrap"}, 2, e_wrap});
        tick();
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            if (s.dut == 0)      obs = rd_main;
            else if (s.dut == 1) obs = 32'(rd_sat);
            else                 obs = 32'(rd_wrap);
            chk(s.tag, obs, s.exp);
        end
    endtask

    task automatic do_snap(input string tag);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        chk(tag, 32'(sv_main), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset state and basic counting
        tick();
        chk("rst_rd", rd_main, 32'd0);
        chk("rst_halt", 32'(halt_main), 32'd0);
        chk("rst_ovf", 32'(ovf_main), 32'd0);
        chk("rst_sv", 32'(sv_main), 32'd0);
        rst = 1'b0;
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            evt[0] = (i % 2 == 0);
            evt[1] = (i < 3);
            tick();
        end
        start = 1'b0;
        evt = 2'b00;
        tick();
        do_snap("t1_snapv");
        rd("t1_sel0", 4'd0, 3'b111, 10, 10, 10);
        chk("t1_snapv_low", 32'(sv_main), 32'd0);
        rd("t1_sel1", 4'd1, 3'b111, 5, 5, 5);
        rd("t1_sel2", 4'd2, 3'b111, 3, 3, 3);
        rd("t1_sel3_oor", 4'd3, 3'b001, 0, 0, 0);
        rd("t1_sel15_oor", 4'd15, 3'b001, 0, 0, 0);
        chk("t1_ovf", 32'(ovf_main), 32'd0);

        // 2. cycle limit halts on the 70th counting edge
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        evt = 2'b01;
        tick();
        repeat (69) tick();
        chk("t2_halt_69", 32'(halt_main), 32'd0);
        tick();
        chk("t2_halt_70", 32'(halt_main), 32'd1);
        do_snap("t2_snapv");
        rd("t2_sel0", 4'd0, 3'b001, 70, 0, 0);
        rd("t2_sel1", 4'd1, 3'b001, 70, 0, 0);
        repeat (10) tick();
        do_snap("t2_snapv2");
        rd("t2_sel0_hold", 4'd0, 3'b001, 70, 0, 0);
        rd("t2_sel1_hold", 4'd1, 3'b001, 70, 0, 0);
        chk("t2_halt_hold", 32'(halt_main), 32'd1);
        clear = 1'b1;
        start = 1'b0;
        evt = 2'b00;
        tick();
        clear = 1'b0;
        chk("t2_halt_clr", 32'(halt_main), 32'd0);
        do_snap("t2_snapv3");
        rd("t2_sel0_clr", 4'd0, 3'b001, 0, 0, 0);
        rd("t2_sel1_clr", 4'd1, 3'b001, 0, 0, 0);

        // 3. overflow on 4-bit instances
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        evt = 2'b10;
        tick();
        repeat (20) tick();
        start = 1'b0;
        evt = 2'b00;
        tick();
        do_snap("t3_snapv");
        chk("t3_snapv_sat", 32'(sv_sat), 32'd1);
        rd("t3_sel2", 4'd2, 3'b111, 20, 15, 4);
        rd("t3_sel0", 4'd0, 3'b111, 20, 15, 4);
        rd("t3_sel1", 4'd1, 3'b111, 0, 0, 0);
        chk("t3_ovf_sat", 32'(ovf_sat), 32'd5);
        chk("t3_ovf_wrap", 32'(ovf_wrap), 32'd5);
        chk("t3_ovf_main", 32'(ovf_main), 32'd0);
        chk("t3_halt_sat", 32'(halt_sat), 32'd0);
        chk("t3_halt_wrap", 32'(halt_wrap), 32'd0);

        // 4. snap and clear together
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        evt = 2'b01;
        repeat (7) tick();
        evt = 2'b00;
        start = 1'b0;
        tick();
        clear = 1'b1;
        do_snap("t4_snapv");
        clear = 1'b0;
        rd("t4_sel1", 4'd1, 3'b111, 7, 7, 7);
        rd("t4_sel0", 4'd0, 3'b111, 7, 7, 7);
        do_snap("t4_snapv2");
        rd("t4_sel1_after", 4'd1, 3'b111, 0, 0, 0);
        rd("t4_sel0_after", 4'd0, 3'b111, 0, 0, 0);

        // 5. clear beats a simultaneous event
        start = 1'b1;
        tick();
        evt = 2'b01;
        repeat (3) tick();
        clear = 1'b1;
        do_snap("t5_snapv");
        clear = 1'b0;
        start = 1'b0;
        evt = 2'b00;
        rd("t5_pre", 4'd1, 3'b111, 3, 3, 3);
        do_snap("t5_snapv2");
        rd("t5_sel1", 4'd1, 3'b111, 0, 0, 0);
        rd("t5_sel0", 4'd0, 3'b111, 0, 0, 0);

        // 6. reset mid-run
        start = 1'b1;
        tick();
        evt = 2'b01;
        rd_sel = 4'd1;
        repeat (20) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        repeat (4) tick();
        chk("t6_rd_pre", rd_main, 32'd20);
        rst = 1'b1;
        snap = 1'b1;
        tick();
        rst = 1'b0;
        snap = 1'b0;
        start = 1'b0;
        evt = 2'b00;
        chk("t6_rd", rd_main, 32'd0);
        chk("t6_sv", 32'(sv_main), 32'd0);
        chk("t6_halt", 32'(halt_main), 32'd0);
        chk("t6_ovf", 32'(ovf_main), 32'd0);
        rd("t6_shadow0", 4'd0, 3'b111, 0, 0, 0);
        rd("t6_shadow1", 4'd1, 3'b111, 0, 0, 0);
        start = 1'b1;
        evt = 2'b01;
        tick();
        repeat (5) tick();
        start = 1'b0;
        evt = 2'b00;
        tick();
        do_snap("t6_snapv");
        rd("t6_sel0", 4'd0, 3'b111, 5, 5, 5);
        rd("t6_sel1", 4'd1, 3'b111, 5, 5, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
